axil_fifo_regs: RTL

AXI4-Lite slave (responder) that exposes a scratch register, a FIFO push window, a FIFO pop window and a status register to an AXI4-Lite master such as the PS or the master VIP. It is the PL-side endpoint of the SimpleAXIFIFO register interface. Software writes words into an internal FIFO and reads them back in order. Errors (overflow, underflow, bad strobes) are reported through BRESP/RRESP and sticky status bits.

---
 rtl/axil_fifo_regs_pkg.sv | 22 ++
 rtl/axil_fifo_regs_fifo.sv | 52 +++++
 rtl/axil_fifo_regs.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_fifo_regs_pkg.sv
// Shared constants and FSM state types for the axil_fifo_regs AXI4-Lite endpoint.
package axil_fifo_regs_pkg;

  // Register offsets, decoded from address bits [3:2].
  localparam logic [1:0] ADDR_SCRATCH = 2'd0;
  localparam logic [1:0] ADDR_PUSH    = 2'd1;
  localparam logic [1:0] ADDR_POP     = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 18;
  localparam int STAT_UNF   = 19;
  localparam int STAT_FLUSH = 31;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_fifo_regs_fifo.sv
// Show-ahead single-clock FIFO: head always presents the oldest entry.
// Push when full and pop when empty are ignored; flush empties it in one cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/axil_fifo_regs.sv
// AXI4-Lite responder exposing SCRATCH, a FIFO push/pop window and STATUS.
// Write and read channels run independent two-state FSMs with registered handshakes.
module axil_fifo_regs
  import axil_fifo_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic              aw_held;
  logic              w_held;
  logic [1:0]        aw_sel_q;
  logic [DW-1:0]     wdata_q;
  logic [SW-1:0]     wstrb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_fire;
  logic [1:0]        wr_sel;
  logic [DW-1:0]     wr_data;
  logic [SW-1:0]     wr_strb;
  logic [1:0]        rd_sel;

  logic [DW-1:0]     scratch;
  logic              ovf;
  logic              unf;

  logic              push_ok;
  logic              pop_ok;
  logic              flush;
  logic              ovf_set;
  logic              ovf_clr;
  logic              unf_set;
  logic              unf_clr;
  logic              scratch_we;
  logic [1:0]        wr_resp;
  logic [DW-1:0]     rd_data;
  logic [1:0]        rd_resp;
  logic [DW-1:0]     status_word;

  logic [DW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  logic              unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_hs   = s00_axi_awvalid & s00_axi_awready;
  assign w_hs    = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs   = s00_axi_arvalid & s00_axi_arready;
  assign wr_fire = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  // The write executes in the cycle the second half arrives, so merge held and live values.
  assign wr_sel  = aw_held ? aw_sel_q : s00_axi_awaddr[3:2];
  assign wr_data = w_held ? wdata_q : s00_axi_wdata;
  assign wr_strb = w_held ? wstrb_q : s00_axi_wstrb;
  assign rd_sel  = s00_axi_araddr[3:2];

  always_comb begin
    status_word                 = '0;
    status_word[15:0]           = 16'(fifo_count);
    status_word[STAT_EMPTY]     = fifo_empty;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_OVF]       = ovf;
    status_word[STAT_UNF]       = unf;
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    push_ok    = 1'b0;
    ovf_set    = 1'b0;
    ovf_clr    = 1'b0;
    unf_clr    = 1'b0;
    flush      = 1'b0;
    scratch_we = 1'b0;
    wr_resp    = RESP_OKAY;
    if (wr_fire) begin
      unique case (wr_sel)
        ADDR_SCRATCH: scratch_we = 1'b1;
        ADDR_PUSH: begin
          if (wr_strb != {SW{1'b1}}) begin
            wr_resp = RESP_SLVERR;
          end else if (fifo_full) begin
            wr_resp = RESP_SLVERR;
            ovf_set = 1'b1;
          end else begin
            push_ok = 1'b1;
          end
        end
        ADDR_POP: wr_resp = RESP_OKAY;
        ADDR_STATUS: begin
          ovf_clr = wr_data[STAT_OVF];
          unf_clr = wr_data[STAT_UNF];
          flush   = wr_data[STAT_FLUSH];
        end
      endcase
    end
  end

  always_comb begin
    pop_ok  = 1'b0;
    unf_set = 1'b0;
    rd_data = '0;
    rd_resp = RESP_OKAY;
    unique case (rd_sel)
      ADDR_SCRATCH: rd_data = scratch;
      ADDR_PUSH:    rd_data = '0;
      ADDR_POP: begin
        if (fifo_empty) begin
          rd_resp = RESP_SLVERR;
          unf_set = ar_hs;
        end else begin
          rd_data = fifo_head;
          pop_ok  = ar_hs;
        end
      end
      ADDR_STATUS:  rd_data = status_word;
    endcase
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk       (s00_axi_aclk),
    .rst       (s00_axi_areset),
    .flush     (flush),
    .push      (push_ok),
    .push_data (wr_data),
    .pop       (pop_ok),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state        <= W_IDLE;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_sel_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RESP_OKAY;
    end else begin
      unique case (wr_state)
        W_IDLE: begin
          if (wr_fire) begin
            wr_state        <= W_RESP;
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b1;
            s00_axi_bresp   <= wr_resp;
          end else begin
            if (aw_hs) begin
              aw_held  <= 1'b1;
              aw_sel_q <= s00_axi_awaddr[3:2];
            end
            if (w_hs) begin
              w_held  <= 1'b1;
              wdata_q <= s00_axi_wdata;
              wstrb_q <= s00_axi_wstrb;
            end
            s00_axi_awready <= ~(aw_held | aw_hs);
            s00_axi_wready  <= ~(w_held | w_hs);
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            wr_state        <= W_IDLE;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rd_state        <= R_IDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RESP_OKAY;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state        <= R_DATA;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b1;
            s00_axi_rdata   <= rd_data;
            s00_axi_rresp   <= rd_resp;
          end else begin
            s00_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            rd_state        <= R_IDLE;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_arready <= 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as a W1C clear wins.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      scratch <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      if (scratch_we) begin
        for (int b = 0; b < SW; b++) begin
          if (wr_strb[b]) scratch[8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      ovf <= (ovf & ~ovf_clr) | ovf_set;
      unf <= (unf & ~unf_clr) | unf_set;
    end
  end

endmodule
